// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store data narrowing, lane replication and byte-enable generation
//
// Purpose:
//   Sits between the EX/MEM register and the data-memory write port. It turns a 32-bit
//   register store into a word-aligned memory write: it replicates the data across the
//   byte lanes, produces byte enables and traps misaligned or reserved-size stores.
//   The latency is one cycle. There are valid/ready handshakes on both sides, and a
//   one-entry skid buffer sits behind the output register.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   flush            synchronous flush; discards every buffered store and same-cycle request
//   in_valid/ready   request handshake; in_ready is registered
//   in_addr/data     byte address and register data of the store
//   in_size          00 byte, 01 half, 10 word, 11 reserved (traps)
//   out_valid/ready  memory write handshake
//   out_addr         word-aligned address
//   out_wdata        lane-replicated write data
//   out_be           byte enables, bit i covers lanes [8i+7:8i]
//   err_valid        one-cycle pulse after a trapped store is accepted
//   err_addr         address of the most recent trapped store
//   err_count        saturating count of traps

module store_align_unit #(
  parameter int BIG_ENDIAN = 0,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_addr,
  input  logic [31:0]          in_data,
  input  logic [1:0]           in_size,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_addr,
  output logic [31:0]          out_wdata,
  output logic [3:0]           out_be,
  output logic                 err_valid,
  output logic [31:0]          err_addr,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [31:0] skid_addr;
  logic [31:0] skid_wdata;
  logic [3:0]  skid_be;

  logic        misaligned;
  logic        accept;
  logic        good;
  logic        trap;
  logic        xfer;
  logic [31:0] new_addr;
  logic [31:0] new_wdata;
  logic [3:0]  new_be;

  logic        load_out;
  logic        load_skid;
  logic        skid_to_out;

  // Trap detection
  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = (in_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // A flush cancels whatever is accepted in the same cycle, including traps.
  assign accept = in_valid & in_ready;
  assign good   = accept & ~misaligned & ~flush;
  assign trap   = accept &  misaligned & ~flush;
  assign xfer   = out_valid & out_ready;

  // Lane formatting. The replicated data is the same in both byte orders; only the
  // enables mirror. Trapped sizes produce don't-care values that are never loaded.
  always_comb begin
    new_addr  = {in_addr[31:2], 2'b00};
    new_wdata = in_data;
    new_be    = 4'b0000;
    case (in_size)
      2'b00: begin
        new_wdata = {4{in_data[7:0]}};
        if (BIG_ENDIAN != 0)
          new_be = 4'b1000 >> in_addr[1:0];
        else
          new_be = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        new_wdata = {2{in_data[15:0]}};
        if (BIG_ENDIAN != 0)
          new_be = in_addr[1] ? 4'b0011 : 4'b1100;
        else
          new_be = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        new_wdata = in_data;
        new_be    = 4'b1111;
      end
      default: begin
        new_wdata = in_data;
        new_be    = 4'b0000;
      end
    endcase
  end

  // Buffer control. The output register always holds the oldest store; the skid only
  // fills when a good store arrives while the output is stalled, so order is preserved.
  always_comb begin
    next_state  = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (good) begin
            next_state = ONE;
            load_out   = 1'b1;
          end
        end
        ONE: begin
          if (good && !xfer) begin
            next_state = TWO;
            load_skid  = 1'b1;
          end else if (good && xfer) begin
            next_state = ONE;
            load_out   = 1'b1;
          end else if (xfer) begin
            next_state = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low in this state, so no accept can coincide with the drain.
          if (xfer) begin
            next_state  = ONE;
            skid_to_out = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  assign out_valid = (state != EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != TWO);
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr  <= '0;
      out_wdata <= '0;
      out_be    <= '0;
    end else if (load_out) begin
      out_addr  <= new_addr;
      out_wdata <= new_wdata;
      out_be    <= new_be;
    end else if (skid_to_out) begin
      out_addr  <= skid_addr;
      out_wdata <= skid_wdata;
      out_be    <= skid_be;
    end
  end

  // Skid register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_addr  <= '0;
      skid_wdata <= '0;
      skid_be    <= '0;
    end else if (flush) begin
      skid_addr  <= '0;
      skid_wdata <= '0;
      skid_be    <= '0;
    end else if (load_skid) begin
      skid_addr  <= new_addr;
      skid_wdata <= new_wdata;
      skid_be    <= new_be;
    end
  end

  // Trap reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      err_valid <= trap;
      if (trap) begin
        err_addr <= in_addr;
        if (err_count != {ERR_CNT_W{1'b1}})
          err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
